display_multiplexado: RTL

Multiplexed 8-digit 7-segment driver for the stopwatch: consumes the BCD time bus produced by the counter (h, min, s, ms digits) and scans it onto one shared segment bus with one-hot digit enables. It captures a tear-free snapshot of the bus once per scan frame, supports a freeze (lap-hold) input, and blanks leading zeros. It sits between the counter and the board's display pins, on the same `NEclk` domain.

---
 rtl/display_multiplexado.sv | 120 ++++++++++++
 1 files changed

// File: rtl/display_multiplexado.sv
// Multiplexed 8-digit 7-segment scanner for the stopwatch time bus.
// Captures a tear-free snapshot per frame, supports lap-hold and leading-zero blanking.
module display_multiplexado #(
    parameter int SCAN_DIV      = 2,
    parameter bit BLANK_LEADING = 1'b1,
    parameter bit COMMON_ANODE  = 1'b0
) (
    input  logic       NEclk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Freeze,
    input  logic [3:0] bcd_h,
    input  logic [3:0] bcd_min_1,
    input  logic [3:0] bcd_min_0,
    input  logic [3:0] bcd_s_1,
    input  logic [3:0] bcd_s_0,
    input  logic [3:0] bcd_ms_2,
    input  logic [3:0] bcd_ms_1,
    input  logic [3:0] bcd_ms_0,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       frame_start
);

    localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_IDLE   = {7{COMMON_ANODE}};
    localparam logic [7:0]    AN_IDLE    = {8{COMMON_ANODE}};

    function automatic logic [6:0] decode7(input logic [3:0] v);
        case (v)
            4'd0:    decode7 = 7'h3F;
            4'd1:    decode7 = 7'h06;
            4'd2:    decode7 = 7'h5B;
            4'd3:    decode7 = 7'h4F;
            4'd4:    decode7 = 7'h66;
            4'd5:    decode7 = 7'h6D;
            4'd6:    decode7 = 7'h7D;
            4'd7:    decode7 = 7'h07;
            4'd8:    decode7 = 7'h7F;
            4'd9:    decode7 = 7'h6F;
            default: decode7 = 7'h40;
        endcase
    endfunction

    function automatic logic is_dp_digit(input logic [2:0] i);
        is_dp_digit = (i == 3'd7) || (i == 3'd5) || (i == 3'd3);
    endfunction

    logic [PW-1:0] presc_p0;
    logic [2:0]    idx_p0;
    logic [31:0]   snap_p0;
    logic          armed_p0;

    logic          tick;
    logic          boundary;
    logic [PW-1:0] presc_nx;
    logic [2:0]    idx_nx;
    logic [31:0]   snap_nx;
    logic [3:0]    digit;
    logic          blank;
    logic          vld_p0;
    logic [6:0]    seg_nx;
    logic          dp_nx;
    logic [7:0]    an_nx;

    // Next-state and display decode, all taken from the post-edge index and snapshot
    always_comb begin
        tick     = Enable && (presc_p0 == PRESC_LAST);
        boundary = tick && (idx_p0 == 3'd7);
        presc_nx = tick ? '0 : presc_p0 + PW'(1);
        idx_nx   = tick ? idx_p0 + 3'd1 : idx_p0;
        snap_nx  = (boundary && !Freeze)
                 ? {bcd_h, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0, bcd_ms_2, bcd_ms_1, bcd_ms_0}
                 : snap_p0;
        digit    = snap_nx[{idx_nx, 2'b00} +: 4];
        blank    = BLANK_LEADING &&
                   (((idx_nx == 3'd7) && (snap_nx[31:28] == 4'd0)) ||
                    ((idx_nx == 3'd6) && (snap_nx[31:28] == 4'd0) && (snap_nx[27:24] == 4'd0)));
        seg_nx   = blank ? 7'h00 : decode7(digit);
        dp_nx    = !blank && is_dp_digit(idx_nx);
        an_nx    = 8'h01 << idx_nx;
        // Display stays dark after reset until the first frame boundary
        vld_p0   = Enable && (armed_p0 || boundary);
    end

    // Stage p0: scan state, snapshot and registered pin drivers
    always_ff @(negedge NEclk) begin
        if (Reset) begin
            presc_p0    <= '0;
            idx_p0      <= 3'd7;
            snap_p0     <= '0;
            armed_p0    <= 1'b0;
            frame_start <= 1'b0;
            seg         <= SEG_IDLE;
            dp          <= COMMON_ANODE;
            an          <= AN_IDLE;
        end else begin
            if (Enable) begin
                presc_p0 <= presc_nx;
                idx_p0   <= idx_nx;
                snap_p0  <= snap_nx;
                if (boundary)
                    armed_p0 <= 1'b1;
            end
            frame_start <= boundary;
            if (vld_p0) begin
                seg <= seg_nx ^ SEG_IDLE;
                dp  <= dp_nx ^ COMMON_ANODE;
                an  <= an_nx ^ AN_IDLE;
            end else begin
                seg <= SEG_IDLE;
                dp  <= COMMON_ANODE;
                an  <= AN_IDLE;
            end
        end
    end

endmodule
